div_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 13 +
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 137 +++++++++++++
 tb/tb_div_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS-subset datapath: divider state encoding and default width.
package cpu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dsr_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // The shifted remainder is kept one bit wider so the compare never overflows.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_sub;

  // Shift {rem, quo} left, then subtract the divisor when it fits and record a 1.
  always_comb begin
    rem_sh  = {rem_in, quo_in[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dsr_mag};
    if (rem_sh >= {1'b0, dsr_mag}) begin
      rem_out = rem_sub[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = rem_sh[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider (DIV): one quotient bit per cycle, sign fix-up, HI = remainder, LO = quotient.
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // Two's-complement magnitudes; the most negative value maps onto itself as an unsigned number.
  assign a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign b_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dsr_mag (dsr_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Next-state, datapath and result fix-up for the divider FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dsr_d      = dsr_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            div_zero_d = 1'b1;
            state_d    = DIV_DONE;
          end else begin
            sign_a_d = dividend[WIDTH-1];
            sign_b_d = divisor[WIDTH-1];
            quo_d    = a_mag;
            dsr_d    = b_mag;
            rem_d    = '0;
            cnt_d    = '0;
            state_d  = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        lo_d       = (sign_a_q ^ sign_b_q) ? (~quo_q + 1'b1) : quo_q;
        hi_d       = sign_a_q ? (~rem_q + 1'b1) : rem_q;
        div_zero_d = 1'b0;
        state_d    = DIV_DONE;
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and working registers; reset clears everything, even mid-division.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dsr_q      <= dsr_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = (state_q == DIV_CALC) || (state_q == DIV_FIX);
  assign done     = (state_q == DIV_DONE);
  assign div_zero = (state_q == DIV_DONE) && div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level reference model plus directed vectors.
module tb_div_unit;

  localparam int W = 32;
  localparam int LAT = W + 2;  // cycles from start to the done pulse

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result by wide signed arithmetic: {remainder, quotient}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Reference model: tracks "cycles since an accepted start" and what HI/LO must hold.
  logic         m_active;
  logic         m_zero;
  int           m_t;
  logic [W-1:0] m_q, m_r;
  logic [W-1:0] exp_hi, exp_lo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_zero   <= 1'b0;
      m_t      <= 0;
      m_q      <= '0;
      m_r      <= '0;
      exp_hi   <= '0;
      exp_lo   <= '0;
    end else if (!m_active) begin
      if (start) begin
        logic [63:0] res;
        res = (divisor == '0) ? 64'd0 : ref_div(dividend, divisor);
        m_active <= 1'b1;
        m_t      <= 1;
        m_zero   <= (divisor == '0);
        m_q      <= res[31:0];
        m_r      <= res[63:32];
      end
    end else if (m_t == (m_zero ? 1 : LAT)) begin
      m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if (!m_zero && (m_t + 1 == LAT)) begin
        exp_lo <= m_q;
        exp_hi <= m_r;
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    logic e_busy, e_done;
    e_busy = m_active && !m_zero && (m_t <= LAT - 1);
    e_done = m_active && (m_t == (m_zero ? 1 : LAT));
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("div_zero", {31'd0, div_zero}, {31'd0, e_done && m_zero});
    chk("hi", hi, exp_hi);
    chk("lo", lo, exp_lo);
  end

  // One division with hand-computed expectations; optionally re-pulse start while busy.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_lo, input logic [31:0] e_hi, input bit e_zero,
                         input int e_lat, input int restart_at);
    int  c, busy_cnt;
    bit  got;
    logic d_zero;
    c = 0; busy_cnt = 0; got = 0; d_zero = 0;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    while (c < 100 && !got) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        got    = 1;
        d_zero = div_zero;
      end else if (restart_at != 0 && c == restart_at) begin
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
      end else if (restart_at == 0 && c == 3) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
    end
    start = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 100 cycles", name);
    end else begin
      chk({name, "_latency"}, c, e_lat);
      chk({name, "_busy_cycles"}, busy_cnt, e_zero ? 0 : e_lat - 1);
      chk({name, "_div_zero"}, {31'd0, d_zero}, {31'd0, e_zero});
      chk({name, "_lo"}, lo, e_lo);
      chk({name, "_hi"}, hi, e_hi);
    end
    $display("div %s: %0d / %0d -> lo=0x%08h hi=0x%08h zero=%0b after %0d cycles",
             name, $signed(a), $signed(b), lo, hi, d_zero, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b0;

    run_div("7_2",     32'd7,          32'd2,          32'h00000003, 32'h00000001, 0, LAT, 0);
    run_div("m7_2",    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 0, LAT, 0);
    run_div("7_m2",    32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 0, LAT, 0);
    run_div("m7_m2",   32'hFFFFFFF9,   32'hFFFFFFFE,   32'h00000003, 32'hFFFFFFFF, 0, LAT, 0);
    run_div("100_7",   32'd100,        32'd7,          32'd14,       32'd2,        0, LAT, 0);
    run_div("5_0",     32'd5,          32'd0,          32'd14,       32'd2,        1, 1,   0);
    run_div("min_m1",  32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 0, LAT, 0);
    run_div("max_1",   32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF, 32'h00000000, 0, LAT, 0);
    run_div("0_5",     32'd0,          32'd5,          32'd0,        32'd0,        0, LAT, 0);
    run_div("1000_3r", 32'd1000,       32'd3,          32'd333,      32'd1,        0, LAT, 10);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    $display("reset asserted mid-division: busy=%0b done=%0b hi=0x%08h lo=0x%08h", busy, done, hi, lo);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_div("9_4",     32'd9,          32'd4,          32'd2,        32'd1,        0, LAT, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
